serial_add_ctrl: RTL



---
 rtl/serial_add_ctrl_if.sv | 23 ++
 rtl/serial_add_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a requester and serial_add_ctrl.
// The Ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
`ifdef SERIAL_ADD_OVF_EN
  logic             Ovf;

  modport master (output start, A, B, Cin, input busy, done, Sum, Carry, Ovf);
  modport slave  (input start, A, B, Cin, output busy, done, Sum, Carry, Ovf);
`else
  modport master (output start, A, B, Cin, input busy, done, Sum, Carry);
  modport slave  (input start, A, B, Cin, output busy, done, Sum, Carry);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared FullAdder walks the operands LSB-first, one bit per clock.
// Optional SERIAL_ADD_OVF_EN adds a registered two's-complement overflow flag (Ovf).
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_ctrl_if.slave  bus
);
  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] sr_shift;

  FullAdder u_fa (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB, so after WIDTH shifts bit 0 holds the LSB.
  assign sr_shift = (sr_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          sa_d    = bus.A;
          sb_d    = bus.B;
          carry_d = bus.Cin;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sr_d    = sr_shift;
        carry_d = fa_co;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          sum_d   = sr_shift;
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          // carry_q is the carry into the MSB, fa_co the carry out of it
          ovf_d   = carry_q ^ fa_co;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.Sum   = sum_q;
  assign bus.Carry = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.Ovf   = ovf_q;
`endif
endmodule
